// File: rtl/serial_subtractor_pkg.sv
// Shared types and defaults for the bit-serial subtractor.
// State encodings and the default operand width live here.
package serial_subtractor_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam int DEFAULT_WIDTH = 8;

endpackage

// File: rtl/full_subtractor.sv
// One-bit full subtractor cell: d = a - b - bi, bo is the borrow out.
module full_subtractor (
  input  logic a,
  input  logic b,
  input  logic bi,
  output logic d,
  output logic bo
);

  assign d  = a ^ b ^ bi;
  assign bo = (~a & b) | (~(a ^ b) & bi);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial A - B - Bin, LSB first, reusing one full-subtractor cell per clock.
// diff/bout update only when an operation completes, so partial results never show.
module serial_subtractor
  import serial_subtractor_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             busy,
  output logic             done
);

  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t          state;
  state_t          state_nxt;
  logic [WIDTH-1:0] sa;
  logic [WIDTH-1:0] sb;
  logic [WIDTH-1:0] sr;
  logic             brw;
  logic [CW-1:0]    cnt;
  logic             d;
  logic             bo;
  logic             last;
  logic             sr_unused;

  full_subtractor u_cell (
    .a  (sa[0]),
    .b  (sb[0]),
    .bi (brw),
    .d  (d),
    .bo (bo)
  );

  assign last = (cnt == LAST);
  // sr[0] is shifted out on the final edge and never needed
  assign sr_unused = sr[0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = IDLE;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE:    state_nxt = start ? SHIFT : IDLE;
      SHIFT: begin
        busy      = 1'b1;
        state_nxt = last ? DONE : SHIFT;
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sa   <= '0;
      sb   <= '0;
      sr   <= '0;
      brw  <= 1'b0;
      cnt  <= '0;
      diff <= '0;
      bout <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            sa  <= a;
            sb  <= b;
            brw <= bin;
            cnt <= '0;
          end
        end
        SHIFT: begin
          sr  <= {d, sr[WIDTH-1:1]};
          sa  <= sa >> 1;
          sb  <= sb >> 1;
          brw <= bo;
          cnt <= cnt + CW'(1);
          if (last) begin
            diff <= {d, sr[WIDTH-1:1]};
            bout <= bo;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed and random checks of serial_subtractor at WIDTH=8 and an exhaustive sweep at WIDTH=4.
module tb_serial_subtractor;

  logic       clk = 1'b0;
  logic       rst = 1'b1;

  logic       start8 = 1'b0;
  logic [7:0] a8 = '0, b8 = '0;
  logic       bin8 = 1'b0;
  logic [7:0] diff8;
  logic       bout8, busy8, done8;

  logic       start4 = 1'b0;
  logic [3:0] a4 = '0, b4 = '0;
  logic       bin4 = 1'b0;
  logic [3:0] diff4;
  logic       bout4, busy4, done4;

  int errors = 0;
  int checks = 0;
  logic [7:0] prev_diff8 = '0;
  logic       prev_bout8 = 1'b0;

  always #5 clk = ~clk;

  serial_subtractor #(.WIDTH(8)) u_dut8 (
    .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8), .bin(bin8),
    .diff(diff8), .bout(bout8), .busy(busy8), .done(done8)
  );

  serial_subtractor #(.WIDTH(4)) u_dut4 (
    .clk(clk), .rst(rst), .start(start4), .a(a4), .b(b4), .bin(bin4),
    .diff(diff4), .bout(bout4), .busy(busy4), .done(done4)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: signed difference, wrapped to the width; borrow when negative.
  function automatic int ref_diff(input int ta, input int tb, input int tbin, input int w);
    int r;
    r = ta - tb - tbin;
    return (r + (1 << w)) % (1 << w);
  endfunction

  function automatic int ref_bout(input int ta, input int tb, input int tbin);
    return (ta - tb - tbin) < 0 ? 1 : 0;
  endfunction

  // Full WIDTH=8 operation with cycle-accurate handshake checks; called at a negedge.
  task automatic op8(input logic [7:0] ta, input logic [7:0] tb, input logic tbin, input string tag);
    a8 = ta; b8 = tb; bin8 = tbin; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    a8 = 8'($urandom); b8 = 8'($urandom); bin8 = 1'($urandom);
    for (int k = 0; k < 8; k++) begin
      chk({tag, "_busy"}, 32'(busy8), 32'(1));
      chk({tag, "_nodone"}, 32'(done8), 32'(0));
      chk({tag, "_hold"}, 32'({prev_bout8, prev_diff8}), 32'({bout8, diff8}) );
      @(negedge clk);
    end
    chk({tag, "_done"}, 32'(done8), 32'(1));
    chk({tag, "_idle_at_done"}, 32'(busy8), 32'(0));
    chk({tag, "_diff"}, 32'(diff8), 32'(ref_diff(int'(ta), int'(tb), int'(tbin), 8)));
    chk({tag, "_bout"}, 32'(bout8), 32'(ref_bout(int'(ta), int'(tb), int'(tbin))));
    prev_diff8 = 8'(ref_diff(int'(ta), int'(tb), int'(tbin), 8));
    prev_bout8 = 1'(ref_bout(int'(ta), int'(tb), int'(tbin)));
    @(negedge clk);
    chk({tag, "_done_fall"}, 32'(done8), 32'(0));
    chk({tag, "_busy_after"}, 32'(busy8), 32'(0));
  endtask

  task automatic op4(input logic [3:0] ta, input logic [3:0] tb, input logic tbin);
    a4 = ta; b4 = tb; bin4 = tbin; start4 = 1'b1;
    @(negedge clk);
    start4 = 1'b0;
    repeat (4) @(negedge clk);
    chk("w4_done", 32'(done4), 32'(1));
    chk("w4_diff", 32'(diff4), 32'(ref_diff(int'(ta), int'(tb), int'(tbin), 4)));
    chk("w4_bout", 32'(bout4), 32'(ref_bout(int'(ta), int'(tb), int'(tbin))));
    @(negedge clk);
  endtask

  logic [7:0] ha [3];
  logic [7:0] hb [3];
  logic       hbin [3];

  initial begin
    #2;
    chk("rst_diff", 32'(diff8), 32'(0));
    chk("rst_bout", 32'(bout8), 32'(0));
    chk("rst_busy", 32'(busy8), 32'(0));
    chk("rst_done", 32'(done8), 32'(0));
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    op8(8'd100, 8'd37, 1'b0, "basic");
    op8(8'h00, 8'h01, 1'b0, "under");
    op8(8'h05, 8'h05, 1'b1, "eqbin");
    op8(8'hFF, 8'h00, 1'b0, "max");

    // start re-pulsed at edges 2 and 8 with new operands must not restart
    a8 = 8'd90; b8 = 8'd17; bin8 = 1'b1; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      if (k == 2 || k == 8) begin
        start8 = 1'b1; a8 = 8'd3; b8 = 8'd250; bin8 = 1'b0;
      end
      @(negedge clk);
      start8 = 1'b0;
    end
    chk("repulse_done", 32'(done8), 32'(1));
    chk("repulse_diff", 32'(diff8), 32'(ref_diff(90, 17, 1, 8)));
    chk("repulse_bout", 32'(bout8), 32'(ref_bout(90, 17, 1)));
    prev_diff8 = diff8 === 8'(ref_diff(90, 17, 1, 8)) ? diff8 : 8'(ref_diff(90, 17, 1, 8));
    prev_bout8 = 1'(ref_bout(90, 17, 1));
    @(negedge clk);
    chk("repulse_no_queue", 32'(busy8), 32'(0));
    @(negedge clk);
    chk("repulse_still_idle", 32'(busy8), 32'(0));

    // asynchronous reset between edges 3 and 4
    a8 = 8'h12; b8 = 8'h34; bin8 = 1'b0; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    repeat (3) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("abort_busy", 32'(busy8), 32'(0));
    chk("abort_done", 32'(done8), 32'(0));
    chk("abort_diff", 32'(diff8), 32'(0));
    chk("abort_bout", 32'(bout8), 32'(0));
    @(negedge clk);
    rst = 1'b0;
    prev_diff8 = '0;
    prev_bout8 = 1'b0;
    @(negedge clk);
    op8(8'd200, 8'd55, 1'b0, "post_rst");

    // start held high: accepts at edges 0, 10, 20
    for (int i = 0; i < 3; i++) begin
      ha[i] = 8'($urandom); hb[i] = 8'($urandom); hbin[i] = 1'($urandom);
    end
    a8 = ha[0]; b8 = hb[0]; bin8 = hbin[0]; start8 = 1'b1;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      chk("held_busy", 32'(busy8), 32'((k % 10) < 8 ? 1 : 0));
      chk("held_done", 32'(done8), 32'((k % 10) == 8 ? 1 : 0));
      chk("held_overlap", 32'(busy8 & done8), 32'(0));
      if ((k % 10) == 8) begin
        chk("held_diff", 32'(diff8),
            32'(ref_diff(int'(ha[k/10]), int'(hb[k/10]), int'(hbin[k/10]), 8)));
        chk("held_bout", 32'(bout8),
            32'(ref_bout(int'(ha[k/10]), int'(hb[k/10]), int'(hbin[k/10]))));
        prev_diff8 = 8'(ref_diff(int'(ha[k/10]), int'(hb[k/10]), int'(hbin[k/10]), 8));
        prev_bout8 = 1'(ref_bout(int'(ha[k/10]), int'(hb[k/10]), int'(hbin[k/10])));
      end
      if ((k % 10) == 9 && k < 20) begin
        a8 = ha[k/10 + 1]; b8 = hb[k/10 + 1]; bin8 = hbin[k/10 + 1];
      end
      if (k == 29) start8 = 1'b0;
    end
    @(negedge clk);
    chk("held_stop", 32'(busy8), 32'(0));

    for (int i = 0; i < 20; i++)
      op8(8'($urandom), 8'($urandom), 1'($urandom), "rand");

    for (int i = 0; i < 512; i++)
      op4(i[3:0], i[7:4], i[8]);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
